// File: rtl/ctrl_pipe_stage_pkg.sv
// Shared definitions for the control-bundle pipeline.
// Bundle layout, LSB first: mem_write, mem_read, mem_to_reg, reg_write, alu_src,
// alu_op[ALUOP_W], rd[RD_W]. A bubble is the all-zero bundle.
package ctrl_pipe_stage_pkg;

  localparam int unsigned MEMWR_BIT   = 0;
  localparam int unsigned MEMRD_BIT   = 1;
  localparam int unsigned MEM2REG_BIT = 2;
  localparam int unsigned REGWR_BIT   = 3;
  localparam int unsigned ALUSRC_BIT  = 4;
  localparam int unsigned ALUOP_OFS   = 5;

  // Total bundle width for the given field widths
  function automatic int unsigned ctrl_w(input int unsigned rd_w, input int unsigned aluop_w);
    return rd_w + aluop_w + 5;
  endfunction

  // Bit offset of the rd field
  function automatic int unsigned rd_ofs(input int unsigned aluop_w);
    return ALUOP_OFS + aluop_w;
  endfunction

  localparam int unsigned                    CTRL_W_DEF  = ctrl_w(5, 2);
  localparam logic [CTRL_W_DEF-1:0]          CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_stage_if.sv
// ID-side bundle between the decoder (master) and the control pipeline (slave).
interface ctrl_pipe_stage_if
  import ctrl_pipe_stage_pkg::*;
#(
  parameter int unsigned RD_W    = 5,
  parameter int unsigned ALUOP_W = 2
) ();

  localparam int unsigned CTRL_W = ctrl_w(RD_W, ALUOP_W);

  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [RD_W-1:0]   id_rs1;
  logic [RD_W-1:0]   id_rs2;
  logic [1:0]        id_rs_used;
  logic              hazard;
  logic              ifid_hold;

  modport master (
    output id_valid, id_ctrl, id_rs1, id_rs2, id_rs_used,
    input  hazard, ifid_hold
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs1, id_rs2, id_rs_used,
    output hazard, ifid_hold
  );

endinterface

// File: rtl/ctrl_pipe_stage_hazard.sv
// Load-use hazard detect: a valid load in stage 0 whose nonzero rd is read by ID.
module ctrl_pipe_stage_hazard
  import ctrl_pipe_stage_pkg::*;
#(
  parameter int unsigned RD_W = 5
) (
  input  logic            id_valid_i,
  input  logic            flush_i,
  input  logic            valid0_i,
  input  logic            mem_read0_i,
  input  logic [RD_W-1:0] rd0_i,
  input  logic [RD_W-1:0] rs1_i,
  input  logic [RD_W-1:0] rs2_i,
  input  logic [1:0]      rs_used_i,
  output logic            hazard_o
);

  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rs1_hit = rs_used_i[0] & (rd0_i == rs1_i);
  assign w_rs2_hit = rs_used_i[1] & (rd0_i == rs2_i);

  // x0 is never a real destination, so a load into it cannot create a dependency
  assign hazard_o = id_valid_i & ~flush_i & valid0_i & mem_read0_i & (rd0_i != '0) &
                    (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/ctrl_pipe_stage.sv
// Control-bundle pipeline: NUM_STAGES registered stages after ID (stage 0 = EX) with load-use
// bubble insertion, external freeze and front-end flush.
// Optional macro CTRL_PERF_CNT_EN adds saturating stall/bubble counters; otherwise they read 0.
module ctrl_pipe_stage
  import ctrl_pipe_stage_pkg::*;
#(
  parameter  int unsigned NUM_STAGES = 3,
  parameter  int unsigned RD_W       = 5,
  parameter  int unsigned ALUOP_W    = 2,
  parameter  int unsigned CNT_W      = 32,
  localparam int unsigned CTRL_W     = ctrl_w(RD_W, ALUOP_W)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  ctrl_pipe_stage_if.slave             id_if,
  input  logic                         stall_i,
  input  logic                         flush_i,
  output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl_o,
  output logic [NUM_STAGES-1:0]        stage_valid_o,
  output logic [CNT_W-1:0]             stall_cnt_o,
  output logic [CNT_W-1:0]             bubble_cnt_o
);

  localparam int unsigned RD_OFS = rd_ofs(ALUOP_W);

  logic [CTRL_W-1:0] r_ctrl  [NUM_STAGES];
  logic              r_valid [NUM_STAGES];
  logic              w_hazard;
  logic              w_hold;

  ctrl_pipe_stage_hazard #(
    .RD_W (RD_W)
  ) u_hazard (
    .id_valid_i  (id_if.id_valid),
    .flush_i     (flush_i),
    .valid0_i    (r_valid[0]),
    .mem_read0_i (r_ctrl[0][MEMRD_BIT]),
    .rd0_i       (r_ctrl[0][RD_OFS +: RD_W]),
    .rs1_i       (id_if.id_rs1),
    .rs2_i       (id_if.id_rs2),
    .rs_used_i   (id_if.id_rs_used),
    .hazard_o    (w_hazard)
  );

  assign w_hold          = w_hazard | stall_i;
  assign id_if.hazard    = w_hazard;
  assign id_if.ifid_hold = w_hold;

  // Stage 0 priority: flush beats freeze, freeze beats hazard bubble, else accept ID
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl[0]  <= '0;
      r_valid[0] <= 1'b0;
    end else if (flush_i) begin
      r_ctrl[0]  <= '0;
      r_valid[0] <= 1'b0;
    end else if (stall_i) begin
      r_ctrl[0]  <= r_ctrl[0];
      r_valid[0] <= r_valid[0];
    end else if (w_hazard || !id_if.id_valid) begin
      r_ctrl[0]  <= '0;
      r_valid[0] <= 1'b0;
    end else begin
      r_ctrl[0]  <= id_if.id_ctrl;
      r_valid[0] <= 1'b1;
    end
  end

  for (genvar k = 1; k < NUM_STAGES; k++) begin : g_stage
    // Downstream stages advance unless the whole chain is frozen
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        r_ctrl[k]  <= '0;
        r_valid[k] <= 1'b0;
      end else if (!stall_i) begin
        r_ctrl[k]  <= r_ctrl[k-1];
        r_valid[k] <= r_valid[k-1];
      end
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_out
    assign stage_ctrl_o[k*CTRL_W +: CTRL_W] = r_ctrl[k];
    assign stage_valid_o[k]                 = r_valid[k];
  end

`ifdef CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic             w_bubble_ins;

  // Invalid-ID bubbles are not counted; only flush- and hazard-inserted ones
  assign w_bubble_ins = flush_i | (~stall_i & w_hazard);

  // Saturating performance counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_stall_cnt  <= '0;
      r_bubble_cnt <= '0;
    end else begin
      if (w_hold && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_bubble_ins && (r_bubble_cnt != '1)) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end
  end

  assign stall_cnt_o  = r_stall_cnt;
  assign bubble_cnt_o = r_bubble_cnt;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Scoreboard bench for ctrl_pipe_stage: the driver predicts each cycle's outputs from a
// queue-based pipeline model and pushes them; a negedge monitor pops and compares.
module tb_ctrl_pipe_stage;
  import ctrl_pipe_stage_pkg::*;

  localparam int unsigned NS      = 3;
  localparam int unsigned RD_W    = 5;
  localparam int unsigned ALUOP_W = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CTRL_W  = RD_W + ALUOP_W + 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 stall;
  logic                 flush;
  logic [NS*CTRL_W-1:0] stage_ctrl;
  logic [NS-1:0]        stage_valid;
  logic [CNT_W-1:0]     scnt;
  logic [CNT_W-1:0]     bcnt;

  always #5 clk = ~clk;

  ctrl_pipe_stage_if #(.RD_W(RD_W), .ALUOP_W(ALUOP_W)) bus ();

  ctrl_pipe_stage #(
    .NUM_STAGES (NS),
    .RD_W       (RD_W),
    .ALUOP_W    (ALUOP_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .id_if         (bus),
    .stall_i       (stall),
    .flush_i       (flush),
    .stage_ctrl_o  (stage_ctrl),
    .stage_valid_o (stage_valid),
    .stall_cnt_o   (scnt),
    .bubble_cnt_o  (bcnt)
  );

  typedef struct {
    logic              v;
    logic [CTRL_W-1:0] c;
  } slot_t;

  typedef struct {
    logic [NS*CTRL_W-1:0] ctrl;
    logic [NS-1:0]        valid;
    logic                 hz;
    logic                 hold;
    logic [CNT_W-1:0]     sc;
    logic [CNT_W-1:0]     bc;
    int                   id;
  } exp_t;

  exp_t  q[$];
  slot_t pipe[$];
  int    m_sc;
  int    m_bc;
  int    n_checks = 0;
  int    n_pass   = 0;
  int    step_id  = 0;
  logic  run      = 1'b0;

  function automatic logic [CTRL_W-1:0] mk(input logic [RD_W-1:0] rd,
                                           input logic [ALUOP_W-1:0] op, input logic src,
                                           input logic wr, input logic m2r, input logic mr,
                                           input logic mw);
    return {rd, op, src, wr, m2r, mr, mw};
  endfunction

  function automatic logic [CNT_W-1:0] sat(input int n);
    int mx;
    mx = (1 << CNT_W) - 1;
    if (n > mx) return mx[CNT_W-1:0];
    return n[CNT_W-1:0];
  endfunction

  task automatic chk(input string name, input int id, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s (step %0d): got %0h, expected %0h", name, id, act, exp);
  endtask

  task automatic model_reset();
    slot_t b;
    b.v = 1'b0;
    b.c = '0;
    pipe.delete();
    for (int k = 0; k < NS; k++) pipe.push_back(b);
    m_sc = 0;
    m_bc = 0;
  endtask

  // One cycle: drive ID, predict outputs for this cycle, advance model across the edge
  task automatic step(input logic v, input logic [CTRL_W-1:0] c, input logic [RD_W-1:0] rs1,
                      input logic [RD_W-1:0] rs2, input logic [1:0] used, input logic st,
                      input logic fl, input logic r);
    exp_t            e;
    slot_t           nw;
    logic [RD_W-1:0] rd0;
    logic            hz;
    bus.id_valid   = v;
    bus.id_ctrl    = c;
    bus.id_rs1     = rs1;
    bus.id_rs2     = rs2;
    bus.id_rs_used = used;
    stall          = st;
    flush          = fl;
    rst            = r;
    rd0 = pipe[0].c[CTRL_W-1 -: RD_W];
    hz  = v && !fl && pipe[0].v && pipe[0].c[1] && (rd0 != 0) &&
          ((used[0] && rd0 == rs1) || (used[1] && rd0 == rs2));
    for (int k = 0; k < NS; k++) begin
      e.ctrl[k*CTRL_W +: CTRL_W] = pipe[k].c;
      e.valid[k]                 = pipe[k].v;
    end
    e.hz   = hz;
    e.hold = hz | st;
`ifdef CTRL_PERF_CNT_EN
    e.sc = sat(m_sc);
    e.bc = sat(m_bc);
`else
    e.sc = '0;
    e.bc = '0;
`endif
    e.id = step_id;
    q.push_back(e);
    step_id++;
    if (r) begin
      model_reset();
    end else begin
      if (hz || st) m_sc++;
      if (fl || (!st && hz)) m_bc++;
      nw.v = v && !fl && !hz;
      nw.c = nw.v ? c : '0;
      if (!st) begin
        pipe.push_front(nw);
        void'(pipe.pop_back());
      end else if (fl) begin
        pipe[0].v = 1'b0;
        pipe[0].c = '0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: one expected record per cycle, compared away from the clock edge
  always @(negedge clk) begin
    if (run) begin
      if (q.size() == 0) begin
        n_checks++;
        $display("FAIL underflow: got no expected record, expected one per cycle");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("stage_ctrl",  e.id, 64'(stage_ctrl),    64'(e.ctrl));
        chk("stage_valid", e.id, 64'(stage_valid),   64'(e.valid));
        chk("hazard",      e.id, 64'(bus.hazard),    64'(e.hz));
        chk("ifid_hold",   e.id, 64'(bus.ifid_hold), 64'(e.hold));
        chk("stall_cnt",   e.id, 64'(scnt),          64'(e.sc));
        chk("bubble_cnt",  e.id, 64'(bcnt),          64'(e.bc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [CTRL_W-1:0] nop;
    logic [CTRL_W-1:0] lw;
    nop = '0;
    bus.id_valid = 1'b0; bus.id_ctrl = '0; bus.id_rs1 = '0; bus.id_rs2 = '0;
    bus.id_rs_used = '0; stall = 1'b0; flush = 1'b0; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    run = 1'b1;
    // Reset state
    step(1'b0, nop, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b1);
    // Plain flow, rd=1..4
    for (int i = 1; i <= 4; i++)
      step(1'b1, mk(RD_W'(i), 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 5'd7, 5'd8, 2'b11,
           1'b0, 1'b0, 1'b0);
    // Load-use on x5, ID re-issues the add after the bubble
    lw = mk(5'd5, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b1, lw, 5'd1, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, mk(5'd6, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 5'd5, 5'd2, 2'b11,
                    1'b0, 1'b0, 1'b0);
    // Load into x0 never stalls
    step(1'b1, mk(5'd0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0), 5'd1, 5'd0, 2'b01,
         1'b0, 1'b0, 1'b0);
    step(1'b1, mk(5'd3, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 5'd0, 5'd0, 2'b11,
         1'b0, 1'b0, 1'b0);
    // Freeze for three cycles mid-stream
    repeat (3) step(1'b1, mk(5'd9, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 5'd1, 5'd1, 2'b01,
                    1'b1, 1'b0, 1'b0);
    // Flush with freeze and a pending load-use hazard on x6
    step(1'b1, mk(5'd6, 2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0), 5'd1, 5'd0, 2'b01,
         1'b0, 1'b0, 1'b0);
    step(1'b1, mk(5'd7, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 5'd6, 5'd0, 2'b01,
         1'b1, 1'b1, 1'b0);
    step(1'b0, nop, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    // Long freeze drives the stall counter into saturation
    repeat (20) step(1'b1, mk(5'd4, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0), 5'd0, 5'd0,
                     2'b00, 1'b1, 1'b0, 1'b0);
    // Reset during a freeze with a hazard-capable load in stage 0
    step(1'b1, lw, 5'd0, 5'd0, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, nop, 5'd5, 5'd0, 2'b01, 1'b1, 1'b0, 1'b1);
    step(1'b1, nop, 5'd5, 5'd0, 2'b01, 1'b0, 1'b0, 1'b0);
    // Randomised traffic with a small register range to provoke hazards
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           mk(RD_W'($urandom_range(0, 3)), ALUOP_W'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom)),
           RD_W'($urandom_range(0, 3)), RD_W'($urandom_range(0, 3)), 2'($urandom),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 99) == 0));
    end
    run = 1'b0;
    chk("drain", step_id, 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
